// File: rtl/ps2_keycode_encoder.sv
// Device-side PS/2 transmitter: key events -> scan-code bytes -> 11-bit frames on ps2Clk/ps2Data.
// Optional typematic repeat is enabled by defining KEY_REPEAT_EN.
module ps2_keycode_encoder #(
  parameter int unsigned CLK_HALF_PERIOD = 1250,
  parameter int unsigned INTER_BYTE_GAP  = 2500,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] keyCode,
  input  logic       make,
  input  logic       brakee,
  input  logic       eventValid,
  output logic       eventReady,
  output logic       ps2Clk,
  output logic       ps2Data,
  output logic       busy,
  output logic [7:0] txByte,
  output logic       byteSent
);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

  typedef struct packed {
    logic [1:0]      n;
    logic [2:0][7:0] b;
  } seq_t;

  localparam int unsigned HALF_LAST = CLK_HALF_PERIOD - 1;
  localparam int unsigned GAP_LAST  = (INTER_BYTE_GAP > 0) ? INTER_BYTE_GAP - 1 : 0;
  // Between bytes of one sequence the LOAD cycle supplies the final idle cycle.
  localparam int unsigned GAP_MID   = (INTER_BYTE_GAP > 1) ? INTER_BYTE_GAP - 2 : 0;

  function automatic seq_t build_seq(input logic [8:0] code, input logic is_break,
                                     input logic is_make);
    seq_t s;
    s = '0;
    if (is_break) begin
      if (code[8]) begin
        s.n    = 2'd3;
        s.b[0] = 8'hE0;
        s.b[1] = 8'hF0;
        s.b[2] = code[7:0];
      end else begin
        s.n    = 2'd2;
        s.b[0] = 8'hF0;
        s.b[1] = code[7:0];
      end
    end else if (is_make) begin
      if (code[8]) begin
        s.n    = 2'd2;
        s.b[0] = 8'hE0;
        s.b[1] = code[7:0];
      end else begin
        s.n    = 2'd1;
        s.b[0] = code[7:0];
      end
    end
    return s;
  endfunction

  state_t          state_q;
  logic [31:0]     cnt_q;
  logic [3:0]      bit_q;
  logic [10:0]     frame_q;
  logic [2:0][7:0] seq_q;
  logic [1:0]      n_q;
  logic [1:0]      idx_q;
  seq_t            ev_seq_d;

  always_comb begin
    ev_seq_d = build_seq(keyCode, brakee, make);
  end

`ifdef KEY_REPEAT_EN
  logic        armed_q;
  logic        rep_run_q;
  logic        ev_make_q;
  logic [8:0]  ev_code_q;
  logic [8:0]  rep_code_q;
  logic [31:0] rep_cnt_q;
  seq_t        rep_seq_d;
  logic        accept_d;
  logic        rep_fire_d;
  logic        seq_done_d;

  always_comb begin
    rep_seq_d  = build_seq(rep_code_q, 1'b0, 1'b1);
    accept_d   = (state_q == IDLE) && eventValid && eventReady;
    rep_fire_d = (state_q == IDLE) && !accept_d && armed_q && (rep_cnt_q == '0);
    seq_done_d = (idx_q == n_q) &&
                 ((state_q == LOAD) || ((state_q == GAP) && (cnt_q == GAP_LAST)));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed_q    <= 1'b0;
      rep_run_q  <= 1'b0;
      ev_make_q  <= 1'b0;
      ev_code_q  <= '0;
      rep_code_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      if (accept_d) begin
        ev_make_q <= make & ~brakee;
        ev_code_q <= keyCode;
        rep_run_q <= 1'b0;
        if (brakee && (keyCode == rep_code_q))
          armed_q <= 1'b0;
      end else if (rep_fire_d) begin
        ev_make_q <= 1'b1;
        ev_code_q <= rep_code_q;
        rep_run_q <= 1'b1;
      end
      // A completed make (new or repeated) retargets and restarts the timer.
      if (seq_done_d && ev_make_q) begin
        armed_q    <= 1'b1;
        rep_code_q <= ev_code_q;
        rep_cnt_q  <= rep_run_q ? REPEAT_PERIOD - 1 : REPEAT_DELAY - 1;
      end else if ((state_q == IDLE) && armed_q && (rep_cnt_q != '0)) begin
        rep_cnt_q <= rep_cnt_q - 32'd1;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '1;
      seq_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      eventReady <= 1'b1;
      busy       <= 1'b0;
      ps2Clk     <= 1'b1;
      ps2Data    <= 1'b1;
      txByte     <= '0;
      byteSent   <= 1'b0;
    end else begin
      byteSent <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (eventValid && eventReady) begin
            seq_q      <= ev_seq_d.b;
            n_q        <= ev_seq_d.n;
            idx_q      <= '0;
            busy       <= 1'b1;
            eventReady <= 1'b0;
            state_q    <= LOAD;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_fire_d) begin
            seq_q      <= rep_seq_d.b;
            n_q        <= rep_seq_d.n;
            idx_q      <= '0;
            busy       <= 1'b1;
            eventReady <= 1'b0;
            state_q    <= LOAD;
          end
`endif
        end
        LOAD: begin
          if (idx_q == n_q) begin
            busy       <= 1'b0;
            eventReady <= 1'b1;
            state_q    <= IDLE;
          end else begin
            txByte  <= seq_q[idx_q];
            frame_q <= {1'b1, ~^seq_q[idx_q], seq_q[idx_q], 1'b0};
            idx_q   <= idx_q + 2'd1;
            bit_q   <= '0;
            cnt_q   <= '0;
            ps2Clk  <= 1'b1;
            ps2Data <= 1'b0;
            state_q <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            ps2Clk  <= 1'b0;
            state_q <= BIT_LO;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        BIT_LO: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q  <= '0;
            ps2Clk <= 1'b1;
            if (bit_q == 4'd10) begin
              ps2Data  <= 1'b1;
              byteSent <= 1'b1;
              state_q  <= GAP;
            end else begin
              bit_q   <= bit_q + 4'd1;
              ps2Data <= frame_q[bit_q + 4'd1];
              state_q <= BIT_HI;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        GAP: begin
          if ((idx_q != n_q) && (cnt_q == GAP_MID)) begin
            cnt_q   <= '0;
            state_q <= LOAD;
          end else if ((idx_q == n_q) && (cnt_q == GAP_LAST)) begin
            cnt_q      <= '0;
            busy       <= 1'b0;
            eventReady <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keycode_encoder.sv
// Directed self-checking bench for ps2_keycode_encoder (half period 4, gap 8).
`timescale 1ns/1ps
module tb_ps2_keycode_encoder;

  localparam int unsigned HP  = 4;
  localparam int unsigned GAP = 8;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [8:0] keyCode = '0;
  logic       make = 1'b0;
  logic       brakee = 1'b0;
  logic       eventValid = 1'b0;
  logic       eventReady;
  logic       ps2Clk;
  logic       ps2Data;
  logic       busy;
  logic [7:0] txByte;
  logic       byteSent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_keycode_encoder #(
    .CLK_HALF_PERIOD(HP),
    .INTER_BYTE_GAP (GAP)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .keyCode   (keyCode),
    .make      (make),
    .brakee    (brakee),
    .eventValid(eventValid),
    .eventReady(eventReady),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .busy      (busy),
    .txByte    (txByte),
    .byteSent  (byteSent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_event(input string tag, input logic [8:0] code, input logic mk,
                            input logic br, input bit hold);
    keyCode    = code;
    make       = mk;
    brakee     = br;
    eventValid = 1'b1;
    chk({tag, "_ready_before"}, {31'd0, eventReady}, 32'd1);
    @(negedge clk);
    chk({tag, "_ready_drop"}, {31'd0, eventReady}, 32'd0);
    chk({tag, "_busy_set"}, {31'd0, busy}, 32'd1);
    if (!hold) eventValid = 1'b0;
  endtask

  task automatic recv_frame(input string tag, input logic [7:0] exp_byte,
                            input logic exp_par, output int t_sent);
    int guard;
    int nb;
    int t0;
    int ready_hi;
    logic prev;
    logic [10:0] bits;
    guard = 0; nb = 0; ready_hi = 0; bits = '0;
    while (!(ps2Data === 1'b0 && ps2Clk === 1'b1) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_start_seen"}, (guard < 4000) ? 32'd1 : 32'd0, 32'd1);
    t0 = cyc; prev = 1'b1; guard = 0;
    while (byteSent !== 1'b1 && guard < 4000) begin
      if (prev === 1'b1 && ps2Clk === 1'b0 && nb < 11) begin
        bits[nb] = ps2Data;
        nb++;
      end
      if (eventReady !== 1'b0) ready_hi++;
      prev = ps2Clk;
      @(negedge clk);
      guard++;
    end
    t_sent = cyc;
    chk({tag, "_falls"}, nb, 32'd11);
    chk({tag, "_bits"}, {21'd0, bits}, {21'd0, 1'b1, exp_par, exp_byte, 1'b0});
    chk({tag, "_len"}, t_sent - t0, 32'd88);
    chk({tag, "_txByte"}, {24'd0, txByte}, {24'd0, exp_byte});
    chk({tag, "_ready_low"}, ready_hi, 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n;
    int low;
    int extra;
    n = 0; low = 0; extra = 0;
    while (eventReady !== 1'b1 && n < 4000) begin
      if (ps2Clk !== 1'b1 || ps2Data !== 1'b1) low++;
      if (n > 0 && byteSent === 1'b1) extra++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_gap"}, n, exp_cycles);
    chk({tag, "_gap_lines"}, low, 32'd0);
    chk({tag, "_single_pulse"}, extra, 32'd0);
    chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t1, t2, t3, viol, guard;

    // 1: reset state and idle lines
    repeat (3) @(negedge clk);
    chk("rst_ps2Clk", {31'd0, ps2Clk}, 32'd1);
    chk("rst_ps2Data", {31'd0, ps2Data}, 32'd1);
    chk("rst_ready", {31'd0, eventReady}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txByte", {24'd0, txByte}, 32'h00);
    chk("rst_byteSent", {31'd0, byteSent}, 32'd0);
    resetN = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2Clk !== 1'b1 || ps2Data !== 1'b1 || eventReady !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("idle_100", viol, 32'd0);

    // 2: make 0x1C, single frame
    send_event("mk1c", 9'h01C, 1'b1, 1'b0, 1'b0);
    chk("mk1c_load_data_hi", {31'd0, ps2Data}, 32'd1);
    @(negedge clk);
    chk("mk1c_first_bithi_data", {31'd0, ps2Data}, 32'd0);
    chk("mk1c_first_bithi_clk", {31'd0, ps2Clk}, 32'd1);
    recv_frame("mk1c", 8'h1C, 1'b0, t1);
    wait_ready("mk1c", 8);

    // 3: break 0x1C -> F0, 1C
    send_event("br1c", 9'h01C, 1'b0, 1'b1, 1'b0);
    recv_frame("br1c_f0", 8'hF0, 1'b1, t1);
    recv_frame("br1c_1c", 8'h1C, 1'b0, t2);
    chk("br1c_spacing", t2 - t1, 32'd96);
    wait_ready("br1c", 8);

    // 4: extended break with eventValid held; a queued no-op event follows
    send_event("br175", 9'h175, 1'b0, 1'b1, 1'b1);
    keyCode = 9'h000; make = 1'b0; brakee = 1'b0;
    recv_frame("br175_e0", 8'hE0, 1'b0, t1);
    recv_frame("br175_f0", 8'hF0, 1'b1, t2);
    recv_frame("br175_75", 8'h75, 1'b0, t3);
    chk("br175_spacing1", t2 - t1, 32'd96);
    chk("br175_spacing2", t3 - t2, 32'd96);
    wait_ready("br175", 8);
    @(negedge clk);
    chk("queued_accept_ready", {31'd0, eventReady}, 32'd0);
    chk("queued_accept_busy", {31'd0, busy}, 32'd1);
    eventValid = 1'b0;
    @(negedge clk);
    chk("noop_ready_back", {31'd0, eventReady}, 32'd1);
    chk("noop_busy_clear", {31'd0, busy}, 32'd0);
    chk("noop_no_byte", {31'd0, byteSent}, 32'd0);
    chk("noop_lines", {30'd0, ps2Clk, ps2Data}, 32'd3);
    chk("noop_txByte_kept", {24'd0, txByte}, 32'h75);

    // 5: make and brakee together -> treated as break
    send_event("both29", 9'h029, 1'b1, 1'b1, 1'b0);
    recv_frame("both29_f0", 8'hF0, 1'b1, t1);
    recv_frame("both29_29", 8'h29, 1'b0, t2);
    chk("both29_spacing", t2 - t1, 32'd96);
    wait_ready("both29", 8);

    // 6: reset during bit 5, then a clean make 0x5A
    send_event("rstmid", 9'h01C, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(ps2Data === 1'b0 && ps2Clk === 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rstmid_start_seen", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
    repeat (45) @(negedge clk);
    chk("rstmid_in_bit5_low", {31'd0, ps2Clk}, 32'd0);
    #2 resetN = 1'b0;
    #1;
    chk("rstmid_ps2Clk", {31'd0, ps2Clk}, 32'd1);
    chk("rstmid_ps2Data", {31'd0, ps2Data}, 32'd1);
    chk("rstmid_ready", {31'd0, eventReady}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_txByte", {24'd0, txByte}, 32'h00);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ps2Clk !== 1'b1 || ps2Data !== 1'b1 || byteSent !== 1'b0) viol++;
    end
    chk("rstmid_quiet_after", viol, 32'd0);
    send_event("mk5a", 9'h05A, 1'b1, 1'b0, 1'b0);
    recv_frame("mk5a", 8'h5A, 1'b1, t1);
    wait_ready("mk5a", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
